restador_8bits_secuencial: RTL and testbench

//  Nibble-serial subtractor: D = A - B - Bi, one NIBBLE-wide slice per clock, LSB slice first.
//  It is the inverse-direction companion of the combinational ripple adders in the datapath.
//  It trades latency for area: one nibble borrow chain is reused WIDTH/NIBBLE times.
//  A start/done handshake connects it to the controller FSM.

---
 rtl/restador_8bits_secuencial_if.sv | 26 ++
 rtl/restador_8bits_secuencial.sv | 121 ++++++++++++
 tb/tb_restador_8bits_secuencial.sv | 132 +++++++++++++
 3 files changed

// File: rtl/restador_8bits_secuencial_if.sv
// Start/done handshake and operand/result bus of the nibble-serial subtractor.
interface restador_8bits_secuencial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             ovf;
    logic             busy;
    logic             done;

    // Controller side: issues requests, observes results
    modport master (
        output start, A, B, Bi,
        input  D, Bo, ovf, busy, done
    );

    // Subtractor side
    modport slave (
        input  start, A, B, Bi,
        output D, Bo, ovf, busy, done
    );
endinterface

// File: rtl/restador_8bits_secuencial.sv
// Nibble-serial subtractor: D = A - B - Bi, one NIBBLE-wide slice per clock,
// least-significant slice first, with a start/busy/done handshake.
module restador_8bits_secuencial #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NIBBLE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    restador_8bits_secuencial_if.slave    bus
);
    localparam int unsigned N     = WIDTH / NIBBLE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    // Elaboration-time guard on the slicing geometry
    generate
        if ((NIBBLE == 0) || (WIDTH % NIBBLE != 0)) begin : g_bad_geometry
            $error("WIDTH must be a non-zero multiple of NIBBLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_d;
    logic               r_bo;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [NIBBLE-1:0]  w_a_slice;
    logic [NIBBLE-1:0]  w_b_slice;
    logic [NIBBLE:0]    w_diff;
    logic [NIBBLE-1:0]  w_s;
    logic               w_b_out;
    logic               w_last;
    logic [WIDTH-1:0]   w_slice_mask;
    logic [WIDTH-1:0]   w_slice_val;

    // One nibble of the borrow chain, reused for every slice
    always_comb begin
        w_a_slice    = NIBBLE'(r_a >> (r_idx * NIBBLE));
        w_b_slice    = NIBBLE'(r_b >> (r_idx * NIBBLE));
        w_diff       = {1'b0, w_a_slice} - {1'b0, w_b_slice} - (NIBBLE+1)'(r_borrow);
        w_s          = w_diff[NIBBLE-1:0];
        w_b_out      = w_diff[NIBBLE];
        w_last       = (r_idx == IDX_W'(N - 1));
        w_slice_mask = WIDTH'({NIBBLE{1'b1}}) << (r_idx * NIBBLE);
        w_slice_val  = WIDTH'(w_s) << (r_idx * NIBBLE);
    end

    // Control FSM with registered datapath and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_d      <= '0;
            r_bo     <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= bus.Bi;
                        r_idx    <= '0;
                        r_d      <= '0;
                        r_bo     <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_borrow <= w_b_out;
                    r_d      <= (r_d & ~w_slice_mask) | w_slice_val;
                    r_idx    <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // Signed overflow of A - B; the borrow-in is deliberately excluded
                        r_bo    <= w_b_out;
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_s[NIBBLE-1] != r_a[WIDTH-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Drive the bus from the output registers
    assign bus.D    = r_d;
    assign bus.Bo   = r_bo;
    assign bus.ovf  = r_ovf;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_restador_8bits_secuencial.sv
// Directed bench for the nibble-serial subtractor.
module tb_restador_8bits_secuencial;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    restador_8bits_secuencial_if #(.WIDTH(8)) bus ();

    restador_8bits_secuencial #(.WIDTH(8), .NIBBLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full transaction: accept, bounded wait for done, result and hold checks
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, input logic [7:0] exp_d, input logic exp_bo,
                          input logic exp_ovf);
        int cyc;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.A = a; bus.B = b; bus.Bi = bi;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.Bi = ~bi;
        check({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
        check({tag, "_done_acc"}, 32'(bus.done), 32'd0);
        check({tag, "_d_clr"},    32'(bus.D),    32'd0);
        check({tag, "_bo_clr"},   32'(bus.Bo),   32'd0);
        check({tag, "_ovf_clr"},  32'(bus.ovf),  32'd0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc),       32'd2);
        check({tag, "_done"},    32'(bus.done),  32'd1);
        check({tag, "_busy_dn"}, 32'(bus.busy),  32'd0);
        check({tag, "_d"},       32'(bus.D),     32'(exp_d));
        check({tag, "_bo"},      32'(bus.Bo),    32'(exp_bo));
        check({tag, "_ovf"},     32'(bus.ovf),   32'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_done_off"}, 32'(bus.done), 32'd0);
        check({tag, "_d_hold"},   32'(bus.D),    32'(exp_d));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.Bi    = 1'b0;

        // Reset state
        #3;
        check("rst_d",    32'(bus.D),    32'd0);
        check("rst_bo",   32'(bus.Bo),   32'd0);
        check("rst_ovf",  32'(bus.ovf),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        #9 rst_n = 1'b1;

        // Basic, wrap-around, signed overflow and inter-nibble borrow cases
        run_op("t1_basic", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);
        run_op("t2_wrap",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("t3a_ovf",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("t3b_ovf",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("t4_chain", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        run_op("t4b_bi",   8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);

        // start held for four cycles with changing operands: one accept only
        @(posedge clk); #1;
        bus.start = 1'b1; bus.A = 8'h35; bus.B = 8'h12; bus.Bi = 1'b0;
        @(posedge clk); #1;
        check("t5_busy_c1", 32'(bus.busy), 32'd1);
        bus.A = 8'h99; bus.B = 8'h11;
        @(posedge clk); #1;
        check("t5_busy_c2", 32'(bus.busy), 32'd1);
        check("t5_done_c2", 32'(bus.done), 32'd0);
        bus.A = 8'hC3; bus.B = 8'h44;
        @(posedge clk); #1;
        check("t5_done",    32'(bus.done), 32'd1);
        check("t5_busy_dn", 32'(bus.busy), 32'd0);
        check("t5_d",       32'(bus.D),    32'h23);
        bus.A = 8'h01; bus.B = 8'h02;
        @(posedge clk); #1;
        check("t5_no_acc_done", 32'(bus.busy), 32'd0);
        check("t5_done_off",    32'(bus.done), 32'd0);
        check("t5_d_hold",      32'(bus.D),    32'h23);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("t5_idle", 32'(bus.busy), 32'd0);
        run_op("t5_next", 8'h44, 8'h04, 1'b0, 8'h40, 1'b0, 1'b0);

        // Reset during the first CALC cycle aborts without a done pulse
        @(posedge clk); #1;
        bus.start = 1'b1; bus.A = 8'h35; bus.B = 8'h12; bus.Bi = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("t6_busy_pre", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_done", 32'(bus.done), 32'd0);
        check("t6_d",    32'(bus.D),    32'd0);
        check("t6_bo",   32'(bus.Bo),   32'd0);
        check("t6_ovf",  32'(bus.ovf),  32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_no_done", 32'(bus.done), 32'd0);
        end
        run_op("t6_after", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
